// File: rtl/i2s_capture_sequencer_pkg.sv
// Shared types for the I2S capture sequencer: session state encoding and word width.
package i2s_pkg;

  localparam int I2S_WORD_W = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    ALIGN   = 3'd2,
    CAPTURE = 3'd3,
    DRAIN   = 3'd4
  } seq_state_t;

endpackage

// File: rtl/axis_reg_slice.sv
// One-entry registered AXI-Stream slice (data + last); push and pop may coincide.
module axis_reg_slice
  import i2s_pkg::*;
#(
  parameter int W = I2S_WORD_W
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         push_in,
  input  logic [W-1:0] push_data_in,
  input  logic         push_last_in,
  input  logic         pop_ready_in,
  output logic         valid_out,
  output logic [W-1:0] data_out,
  output logic         last_out,
  output logic         can_accept_out
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         last_q, last_d;
  logic         pop;

  assign pop            = valid_q & pop_ready_in;
  assign can_accept_out = ~valid_q | pop_ready_in;
  assign valid_out      = valid_q;
  assign data_out       = data_q;
  assign last_out       = last_q;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    if (push_in) begin
      valid_d = 1'b1;
      data_d  = push_data_in;
      last_d  = push_last_in;
    end else if (pop) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
    end
  end

endmodule

// File: rtl/i2s_capture_sequencer.sv
// Capture-session sequencer between i2s_receiver and the consumer.
// Build option I2S_SEQ_OVERFLOW_EN: real-time input (tready tied 1), drops flagged on overflow_out.
module i2s_capture_sequencer
  import i2s_pkg::*;
#(
  parameter int SETTLE_FRAMES = 4096,
  parameter int LEN_W         = 16
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  input  logic                  start_in,
  input  logic                  stop_in,
  input  logic [LEN_W-1:0]      length_in,
  input  logic                  ws_in,
  output logic                  i2s_en_out,
  input  logic                  s_axis_tvalid,
  input  logic [I2S_WORD_W-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  output logic                  s_axis_tready,
  output logic                  m_axis_tvalid,
  output logic [I2S_WORD_W-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  input  logic                  m_axis_tready,
  output logic                  busy_out,
  output logic [LEN_W-1:0]      frames_out,
  output logic                  overflow_out
);

  localparam int CNT_W = $clog2(SETTLE_FRAMES + 2);
`ifdef I2S_SEQ_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  seq_state_t       state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] frames_q, frames_d;
  logic [CNT_W-1:0] settle_cnt_q, settle_cnt_d;
  logic             ovf_q, ovf_d;
  logic             stop_pend_q, stop_pend_d;
  logic             ws_prev_q;

  logic ws_rise, settle_hit, s_accept;
  logic push, drop, stop_now;
  logic slice_can_accept;

  assign ws_rise    = ws_in & ~ws_prev_q;
  assign settle_hit = (settle_cnt_q == CNT_W'(SETTLE_FRAMES));
  assign s_accept   = s_axis_tvalid & s_axis_tready;

`ifdef I2S_SEQ_OVERFLOW_EN
  assign s_axis_tready = 1'b1;
`else
  assign s_axis_tready = (state_q == CAPTURE) ? slice_can_accept : 1'b1;
`endif

  assign i2s_en_out   = (state_q != IDLE);
  assign busy_out     = (state_q != IDLE);
  assign frames_out   = frames_q;
  assign overflow_out = ovf_q;

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    frames_d     = frames_q;
    settle_cnt_d = settle_cnt_q;
    ovf_d        = ovf_q;
    stop_pend_d  = stop_pend_q;
    push         = 1'b0;
    drop         = 1'b0;
    stop_now     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_in) begin
          state_d      = SETTLE;
          len_d        = length_in;
          frames_d     = '0;
          settle_cnt_d = '0;
          ovf_d        = 1'b0;
          stop_pend_d  = 1'b0;
        end
      end
      SETTLE: begin
        if (stop_in)         state_d = DRAIN;
        else if (settle_hit) state_d = ALIGN;
        else if (ws_rise)    settle_cnt_d = settle_cnt_q + CNT_W'(1);
      end
      ALIGN: begin
        if (stop_in)                        state_d = DRAIN;
        else if (s_accept && s_axis_tlast)  state_d = CAPTURE;
      end
      CAPTURE: begin
        // A stop arriving on the same cycle as a tlast push closes that frame.
        stop_now = stop_pend_q | stop_in;
        if (stop_in) stop_pend_d = 1'b1;
        push = s_axis_tvalid & slice_can_accept;
        drop = OVF_EN & s_axis_tvalid & ~slice_can_accept;
        if (drop) ovf_d = 1'b1;
        if (push && s_axis_tlast) begin
          frames_d = frames_q + LEN_W'(1);
          if (((len_q != '0) && (frames_d == len_q)) || stop_now) begin
            state_d     = DRAIN;
            stop_pend_d = 1'b0;
          end
        end
      end
      DRAIN: begin
        if (!m_axis_tvalid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q      <= IDLE;
      len_q        <= '0;
      frames_q     <= '0;
      settle_cnt_q <= '0;
      ovf_q        <= 1'b0;
      stop_pend_q  <= 1'b0;
      ws_prev_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      frames_q     <= frames_d;
      settle_cnt_q <= settle_cnt_d;
      ovf_q        <= ovf_d;
      stop_pend_q  <= stop_pend_d;
      ws_prev_q    <= ws_in;
    end
  end

  axis_reg_slice #(.W(I2S_WORD_W)) u_slice (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .push_in        (push),
    .push_data_in   (s_axis_tdata),
    .push_last_in   (s_axis_tlast),
    .pop_ready_in   (m_axis_tready),
    .valid_out      (m_axis_tvalid),
    .data_out       (m_axis_tdata),
    .last_out       (m_axis_tlast),
    .can_accept_out (slice_can_accept)
  );

endmodule

// File: tb/tb_i2s_capture_sequencer.sv
// Directed + randomized bench for i2s_capture_sequencer with a frame-level reference model.
module tb_i2s_capture_sequencer;

  localparam int LW = 16;

  logic          clk_in = 1'b0;
  logic          rst_in = 1'b1;
  logic          start_in = 1'b0;
  logic          stop_in = 1'b0;
  logic [LW-1:0] length_in = '0;
  logic          ws_in = 1'b0;
  logic          i2s_en_out;
  logic          s_axis_tvalid = 1'b0;
  logic [31:0]   s_axis_tdata = '0;
  logic          s_axis_tlast = 1'b0;
  logic          s_axis_tready;
  logic          m_axis_tvalid;
  logic [31:0]   m_axis_tdata;
  logic          m_axis_tlast;
  logic          m_axis_tready = 1'b1;
  logic          busy_out;
  logic [LW-1:0] frames_out;
  logic          overflow_out;

  int total = 0;
  int bad   = 0;
  logic [32:0] exp_q[$];
  logic [32:0] got_q[$];
  logic [32:0] sent_q[$];

  always #5 clk_in = ~clk_in;

  i2s_capture_sequencer #(.SETTLE_FRAMES(4), .LEN_W(LW)) dut (
    .clk_in        (clk_in),
    .rst_in        (rst_in),
    .start_in      (start_in),
    .stop_in       (stop_in),
    .length_in     (length_in),
    .ws_in         (ws_in),
    .i2s_en_out    (i2s_en_out),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .busy_out      (busy_out),
    .frames_out    (frames_out),
    .overflow_out  (overflow_out)
  );

  // Output monitor: a handshake seen here completes on the next rising edge.
  always @(negedge clk_in) begin
    if (m_axis_tvalid && m_axis_tready) got_q.push_back({m_axis_tlast, m_axis_tdata});
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic gap(input int n);
    repeat (n) tick();
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    @(negedge clk_in);
    chk({tag, "_en"},     i2s_en_out, 0);
    chk({tag, "_mvalid"}, m_axis_tvalid, 0);
    chk({tag, "_mdata"},  m_axis_tdata, 0);
    chk({tag, "_mlast"},  m_axis_tlast, 0);
    chk({tag, "_busy"},   busy_out, 0);
    chk({tag, "_frames"}, frames_out, 0);
    chk({tag, "_ovf"},    overflow_out, 0);
    chk({tag, "_sready"}, s_axis_tready, 1);
  endtask

  task automatic send_beat(input logic [31:0] d, input logic l);
    bit acc;
    acc = 1'b0;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = d;
    s_axis_tlast  = l;
    for (int k = 0; k < 100 && !acc; k++) begin
      @(negedge clk_in);
      acc = s_axis_tready;
      tick();
    end
    s_axis_tvalid = 1'b0;
    if (!acc) chk("send_timeout", 0, 1);
  endtask

  task automatic send_cap(input logic [31:0] d, input logic l);
    sent_q.push_back({l, d});
    send_beat(d, l);
  endtask

  task automatic ws_edges(input int n);
    repeat (n) begin
      ws_in = 1'b1; gap(2);
      ws_in = 1'b0; gap(2);
    end
  endtask

  // Start, check the session opened, then walk the mic through its settle interval.
  // A tlast beat sent after only 3 WS edges must be swallowed by the settle phase.
  task automatic open_session(input int len);
    length_in = LW'(len);
    start_in = 1'b1;
    tick();
    start_in = 1'b0;
    length_in = LW'($urandom);
    @(negedge clk_in);
    chk("busy_after_start", busy_out, 1);
    chk("en_after_start", i2s_en_out, 1);
    chk("ovf_cleared", overflow_out, 0);
    chk("frames_cleared", frames_out, 0);
    ws_edges(3);
    send_beat($urandom, 1'b1);
    ws_edges(1);
    gap(3);
    sent_q.delete();
  endtask

  // Reference: skip through the first frame end, then forward whole frames until the
  // requested count is met or a frame ends after the stop request.
  task automatic model_session(input int len, input int stop_idx, output int nfr);
    bit aligned, done;
    aligned = 1'b0;
    done = 1'b0;
    nfr = 0;
    for (int i = 0; i < sent_q.size(); i++) begin
      if (!done) begin
        if (!aligned) aligned = sent_q[i][32];
        else begin
          exp_q.push_back(sent_q[i]);
          if (sent_q[i][32]) begin
            nfr++;
            if ((len != 0 && nfr == len) || (stop_idx >= 0 && i >= stop_idx)) done = 1'b1;
          end
        end
      end
    end
    sent_q.delete();
  endtask

  task automatic wait_idle(input string tag);
    bit idle;
    idle = 1'b0;
    for (int k = 0; k < 60 && !idle; k++) begin
      @(negedge clk_in);
      idle = !busy_out;
      if (!idle) tick();
    end
    chk({tag, "_idle"}, idle, 1);
    chk({tag, "_en_low"}, i2s_en_out, 0);
  endtask

  task automatic check_sb(input string tag);
    logic [32:0] g;
    chk({tag, "_beats"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < got_q.size()) ? got_q[i] : 33'h0_dead_beef;
      chk({tag, "_beat"}, g, exp_q[i]);
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic finish_session(input string tag, input int len, input int stop_idx);
    int nfr;
    model_session(len, stop_idx, nfr);
    wait_idle(tag);
    chk({tag, "_frames"}, frames_out, nfr[LW-1:0]);
    check_sb(tag);
  endtask

  initial begin
    int stop_idx;
    int len;
    logic [31:0] a, b, c, d, e, f;

    // Reset values
    gap(2);
    chk_reset_vals("reset");
    rst_in = 1'b0;
    tick();

    // Bounded capture of 3 frames; an extra frame afterwards must not appear.
    open_session(3);
    send_cap($urandom, 1'b1);
    for (int fr = 0; fr < 4; fr++) begin
      send_cap($urandom, 1'b0);
      send_cap($urandom, 1'b1);
    end
    finish_session("len3", 3, -1);

    // Continuous mode, stop mid-frame after 5 frames: the in-flight frame completes.
    open_session(0);
    send_cap($urandom, 1'b0);
    send_cap($urandom, 1'b1);
    for (int fr = 0; fr < 5; fr++) begin
      send_cap($urandom, 1'b0);
      send_cap($urandom, 1'b1);
    end
    send_cap($urandom, 1'b0);
    stop_idx = sent_q.size();
    stop_in = 1'b1; tick(); stop_in = 1'b0;
    send_cap($urandom, 1'b1);
    send_cap($urandom, 1'b0);
    send_cap($urandom, 1'b1);
    finish_session("stop_cont", 0, stop_idx);

    // Randomized lengths, partial leading frames and inter-beat gaps.
    for (int s = 0; s < 3; s++) begin
      len = $urandom_range(1, 4);
      open_session(len);
      if ($urandom_range(0, 1) == 1) send_cap($urandom, 1'b0);
      send_cap($urandom, 1'b1);
      for (int fr = 0; fr <= len; fr++) begin
        gap($urandom_range(0, 2));
        send_cap($urandom, 1'b0);
        gap($urandom_range(0, 2));
        send_cap($urandom, 1'b1);
      end
      finish_session("rand", len, -1);
    end

    // Stop while settling: back to idle within two cycles, nothing forwarded.
    length_in = LW'(2);
    start_in = 1'b1; tick(); start_in = 1'b0;
    ws_edges(1);
    stop_in = 1'b1; tick(); stop_in = 1'b0;
    gap(1);
    @(negedge clk_in);
    chk("settle_stop_busy", busy_out, 0);
    chk("settle_stop_en", i2s_en_out, 0);
    send_beat($urandom, 1'b0);
    send_beat($urandom, 1'b1);
    gap(2);
    chk("settle_stop_frames", frames_out, 0);
    check_sb("settle_stop");

    // Consumer stalls for three beats during capture.
    open_session(2);
    send_beat($urandom, 1'b1);
    m_axis_tready = 1'b0;
    a = $urandom; b = $urandom; c = $urandom;
    d = $urandom; e = $urandom; f = $urandom;
`ifdef I2S_SEQ_OVERFLOW_EN
    send_beat(a, 1'b0);
    send_beat(b, 1'b1);
    send_beat(c, 1'b0);
    @(negedge clk_in);
    chk("ovf_set", overflow_out, 1);
    chk("ovf_held_valid", m_axis_tvalid, 1);
    chk("ovf_held_data", m_axis_tdata, a);
    chk("ovf_frames", frames_out, 0);
    tick();
    m_axis_tready = 1'b1;
    send_beat(d, 1'b1);
    send_beat(e, 1'b0);
    send_beat(f, 1'b1);
    exp_q.push_back({1'b0, a});
    exp_q.push_back({1'b1, d});
    exp_q.push_back({1'b0, e});
    exp_q.push_back({1'b1, f});
`else
    send_beat(a, 1'b0);
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = b;
    s_axis_tlast  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk_in);
      chk("bp_sready_low", s_axis_tready, 0);
      chk("bp_no_ovf", overflow_out, 0);
      chk("bp_held_data", m_axis_tdata, a);
      tick();
    end
    m_axis_tready = 1'b1;
    send_beat(b, 1'b1);
    send_beat(c, 1'b0);
    send_beat(d, 1'b1);
    exp_q.push_back({1'b0, a});
    exp_q.push_back({1'b1, b});
    exp_q.push_back({1'b0, c});
    exp_q.push_back({1'b1, d});
`endif
    wait_idle("stall");
    chk("stall_frames", frames_out, 2);
    check_sb("stall");

    // Push and pop every cycle; a second start while busy must not relatch the length.
    open_session(3);
    length_in = LW'(9);
    start_in = 1'b1; tick(); start_in = 1'b0;
    send_cap($urandom, 1'b1);
    for (int i = 1; i <= 6; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = 32'(i) << 24;
      s_axis_tlast  = (i % 2 == 0);
      sent_q.push_back({s_axis_tlast, s_axis_tdata});
      @(negedge clk_in);
      chk("pp_sready", s_axis_tready, 1);
      if (i > 1) begin
        chk("pp_valid", m_axis_tvalid, 1);
        chk("pp_data", m_axis_tdata, 32'(i - 1) << 24);
      end
      tick();
    end
    s_axis_tvalid = 1'b0;
    @(negedge clk_in);
    chk("pp_last_data", m_axis_tdata, 32'h0600_0000);
    chk("pp_last_flag", m_axis_tlast, 1);
    finish_session("pushpop", 3, -1);

    // Reset in the middle of capture with the slice holding a beat.
    open_session(0);
    send_beat($urandom, 1'b1);
    m_axis_tready = 1'b0;
    send_beat($urandom, 1'b0);
    @(negedge clk_in);
    chk("pre_rst_full", m_axis_tvalid, 1);
    tick();
    rst_in = 1'b1;
    tick();
    rst_in = 1'b0;
    chk_reset_vals("midrst");
    m_axis_tready = 1'b1;
    gap(3);
    check_sb("midrst");

    // A fresh session still works after the reset.
    open_session(1);
    send_cap($urandom, 1'b1);
    send_cap($urandom, 1'b0);
    send_cap($urandom, 1'b1);
    send_cap($urandom, 1'b0);
    send_cap($urandom, 1'b1);
    finish_session("post_rst", 1, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
